control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/ctrl_pkg.sv | 80 ++++++++
 rtl/cu_decode.sv | 32 +++
 rtl/control_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode map, FSM state encoding, instruction classes and the strobe bundle
// used by the control unit and its opcode decoder.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_FETCH_IDLE, S_FETCH0, S_FETCH1, S_FETCH2,
        S_T3, S_T4, S_T5, S_T6, S_T7,
        S_DIV_WAIT, S_DIV_DONE, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST, CLS_MUL, CLS_DIV, CLS_NEGNOT,
        CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } instr_class_t;

    typedef struct packed {
        logic       run;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       ba_out;
        logic       con_in;
        logic       reset_div;
        logic       rin;
        logic       r_out;
        logic       mdr_rd;
        logic       mar_rd;
        logic       hi_rd;
        logic       lo_rd;
        logic       zhi_rd;
        logic       zlo_rd;
        logic       pc_rd;
        logic       out_rd;
        logic       y_rd;
        logic       ir_rd;
        logic       mdr_out;
        logic       hi_out;
        logic       lo_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       pc_out;
        logic       in_out;
        logic       c_out;
        logic [4:0] op_sel;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-instruction-class decode; unlisted opcodes behave as nop.
module cu_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = CLS_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:         cls = CLS_ALU_I;
            OP_LD:                            cls = CLS_LD;
            OP_LDI:                           cls = CLS_LDI;
            OP_ST:                            cls = CLS_ST;
            OP_MUL:                           cls = CLS_MUL;
            OP_DIV:                           cls = CLS_DIV;
            OP_NEG, OP_NOT:                   cls = CLS_NEGNOT;
            OP_BR:                            cls = CLS_BR;
            OP_JR:                            cls = CLS_JR;
            OP_IN:                            cls = CLS_IN;
            OP_OUT:                           cls = CLS_OUT;
            OP_MFHI:                          cls = CLS_MFHI;
            OP_MFLO:                          cls = CLS_MFLO;
            OP_HALT:                          cls = CLS_HALT;
            default:                          cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch, per-class execute steps, divider wait and halt.
// Strobes decode from the state register plus the (registered) IR and CON.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        calc_finished,
    output logic        run,
    output logic        IncPC, Read, Write, Gra, Grb, Grc, BAout, CONin, reset_div, Rin, R_out,
    output logic        MDR_rd, MAR_rd, HI_rd, LO_rd, Zhi_rd, Zlo_rd, PC_rd, Out_rd, Y_rd, IR_rd,
    output logic        MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, In_out, C_out,
    output logic [4:0]  op_sel
);

    state_t       state, next_state;
    instr_class_t cls;
    ctrl_t        c;
    logic [4:0]   opcode;
    logic         unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    cu_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH_IDLE: next_state = S_FETCH0;
            S_FETCH0:     next_state = stop ? S_HALT : S_FETCH1;
            S_FETCH1:     next_state = S_FETCH2;
            S_FETCH2:     next_state = S_T3;
            S_T3: begin
                case (cls)
                    CLS_HALT:                 next_state = S_HALT;
                    CLS_DIV:                  next_state = S_DIV_WAIT;
                    CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST,
                    CLS_MUL, CLS_NEGNOT, CLS_BR: next_state = S_T4;
                    default:                  next_state = S_FETCH0;
                endcase
            end
            S_T4:         next_state = (cls == CLS_NEGNOT) ? S_FETCH0 : S_T5;
            S_DIV_WAIT:   next_state = calc_finished ? S_DIV_DONE : S_DIV_WAIT;
            S_DIV_DONE:   next_state = S_T5;
            S_T5:         next_state = (cls == CLS_LD || cls == CLS_ST || cls == CLS_MUL ||
                                        cls == CLS_DIV || cls == CLS_BR) ? S_T6 : S_FETCH0;
            S_T6:         next_state = (cls == CLS_LD || cls == CLS_ST) ? S_T7 : S_FETCH0;
            S_T7:         next_state = S_FETCH0;
            S_HALT:       next_state = S_HALT;
            default:      next_state = S_FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr)
            state <= S_FETCH_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        c     = '0;
        c.run = (state != S_FETCH_IDLE) && (state != S_HALT);
        case (state)
            S_FETCH0: begin c.pc_out = 1'b1; c.mar_rd = 1'b1; c.inc_pc = 1'b1; end
            S_FETCH1: begin c.read = 1'b1; c.mdr_rd = 1'b1; end
            S_FETCH2: begin c.mdr_out = 1'b1; c.ir_rd = 1'b1; end
            S_T3: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1; end
                    CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_rd = 1'b1; end
                    CLS_MUL:    begin c.gra = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1; end
                    CLS_DIV:    begin c.gra = 1'b1; c.r_out = 1'b1; c.y_rd = 1'b1; c.reset_div = 1'b1; end
                    CLS_NEGNOT: begin c.grb = 1'b1; c.r_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = opcode; end
                    CLS_BR:     begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                    CLS_JR:     begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_rd = 1'b1; end
                    CLS_IN:     begin c.in_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_OUT:    begin c.gra = 1'b1; c.r_out = 1'b1; c.out_rd = 1'b1; end
                    CLS_MFHI:   begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_MFLO:   begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_ALU_R: begin c.grc = 1'b1; c.r_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = opcode; end
                    CLS_ALU_I: begin c.c_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = opcode; end
                    CLS_LD, CLS_LDI, CLS_ST: begin c.c_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = ALU_ADD; end
                    CLS_MUL: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.zhi_rd = 1'b1; c.zlo_rd = 1'b1; c.op_sel = opcode;
                    end
                    CLS_NEGNOT: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_BR:     begin c.pc_out = 1'b1; c.y_rd = 1'b1; end
                    default: ;
                endcase
            end
            S_DIV_WAIT: begin c.grb = 1'b1; c.r_out = 1'b1; end
            S_DIV_DONE: begin
                c.grb = 1'b1; c.r_out = 1'b1; c.zhi_rd = 1'b1; c.zlo_rd = 1'b1; c.op_sel = opcode;
            end
            S_T5: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_LD, CLS_ST:   begin c.zlo_out = 1'b1; c.mar_rd = 1'b1; end
                    CLS_MUL, CLS_DIV: begin c.zlo_out = 1'b1; c.lo_rd = 1'b1; end
                    CLS_BR:           begin c.c_out = 1'b1; c.zlo_rd = 1'b1; c.op_sel = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD:           begin c.read = 1'b1; c.mdr_rd = 1'b1; end
                    CLS_ST:           begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_rd = 1'b1; end
                    CLS_MUL, CLS_DIV: begin c.zhi_out = 1'b1; c.hi_rd = 1'b1; end
                    CLS_BR:           begin c.zlo_out = CON; c.pc_rd = CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD:  begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_ST:  c.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign {run, IncPC, Read, Write, Gra, Grb, Grc, BAout, CONin, reset_div, Rin, R_out,
            MDR_rd, MAR_rd, HI_rd, LO_rd, Zhi_rd, Zlo_rd, PC_rd, Out_rd, Y_rd, IR_rd,
            MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, In_out, C_out, op_sel} = c;

endmodule
